fas_stream_src: RTL and testbench
=================================

FAS_STREAM_SRC -- requirements
Module: fas_stream_src

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame.
- len  in  10  frame length in samples; sampled on accepted start; 0 means 1024.
- pause  in  1  hold request; freezes the stream while high.
- mem_en  out  1  read enable to the pattern RAM.
- mem_addr  out  10  RAM word address.
- mem_rdata  in  16  RAM read data, valid exactly 1 cycle after mem_en.
- data_valid  out  1  sample strobe to FAS.
- data  out  16  sample to FAS, 4.12-style fixed point, passed through unmodified.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last flush sample.
REQ-002 Parameter FLUSH_LEN, default 16: number of zero samples streamed after the frame with data_valid high.

Function
REQ-003 FSM states SHALL be IDLE, PRIME, STREAM, FLUSH, FIN.
REQ-004 In IDLE with start=1, the block SHALL:
- latch len into a length register (0 maps to 1024);
- clear the address counter;
- assert busy;
- enter PRIME.
REQ-005 start SHALL be ignored in any state other than IDLE.
REQ-006 In PRIME with pause=0, the block SHALL issue mem_en=1 with mem_addr=0 and enter STREAM.
REQ-007 First data_valid SHALL occur exactly 2 cycles after the PRIME read (read, then register), giving start-to-first-sample latency of 3 cycles with pause low.
REQ-008 In STREAM, with pause low, the block SHALL:
- issue one read per cycle at consecutive addresses 0..L-1;
- present one sample per cycle on data with data_valid=1, in address order, with no gaps.
REQ-009 While pause=1:
- mem_en SHALL be 0 and the address SHALL hold;
- data_valid SHALL be 0 from the next cycle;
- the single read still in flight SHALL be captured in the one-entry skid register.
REQ-010 After pause falls, the block SHALL:
- emit the skid entry first;
- resume reads, with no sample lost or duplicated.
REQ-011 After sample L-1 has been emitted, the block SHALL enter FLUSH and output data=0 with data_valid=1 for FLUSH_LEN cycles; pause SHALL also freeze FLUSH.
REQ-012 FIN SHALL:
- last 1 cycle with done=1;
- drop busy in the same cycle;
- return to IDLE.
REQ-013 data SHALL read 0 whenever data_valid=0.
REQ-014 The address counter SHALL be 11 bits internally so that L=1024 terminates without wrap; mem_addr SHALL be its low 10 bits.
REQ-015 pause in IDLE or FIN SHALL have no effect.
REQ-016 start and pause high in the same IDLE cycle SHALL latch the frame; PRIME SHALL then wait until pause=0.

Reset
REQ-017 When rst=0 at a rising edge, the block SHALL:
- enter IDLE;
- drive mem_en, mem_addr, data_valid, data, busy and done to 0;
- clear the length register and the skid register.
REQ-018 Reset asserted mid-frame SHALL abort immediately; the in-flight read SHALL be discarded; the next start SHALL begin at address 0.

Structure
REQ-019 Package fas_pkg SHALL hold:
- SAMPLE_W=16, ADDR_W=10, MAX_LEN=1024, default FLUSH_LEN;
- the FSM state enum.
REQ-020 The one-entry skid buffer SHALL be a sub-module fas_src_skid (valid flag plus 16-bit register; load, pop, clear).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- len=0, pause low, RAM[a]=a: data_valid high for 1040 consecutive cycles; data 0x0000..0x03FF then 16 zeros; done 1 cycle after; first sample 3 cycles after start.
- len=4, RAM=0xAAAA,0xBBBB,0xCCCC,0xDDDD: samples in that order, then 16 zeros, then done; busy high for 4+16+3+1 cycles.
- len=8, pause high for 5 cycles at the 3rd sample: output sequence equals RAM[0..7] with no loss or repeat; data_valid low for exactly 5 cycles; data=0 during the gap.
- start pulsed again while busy: no effect; exactly one done.
- rst=0 at the 100th sample of a len=0 frame: all outputs 0 next cycle; new start streams from address 0.
- start and pause together, pause held 3 cycles: first mem_en 1 cycle after pause falls.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared types and sizing for the FAS stream source: sample/address widths,
// frame limits and the sequencer state encoding.
package fas_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int ADDR_W        = 10;
  localparam int CNT_W         = ADDR_W + 1;
  localparam int MAX_LEN       = 1024;
  localparam int DEF_FLUSH_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    FLUSH,
    FIN
  } fas_state_e;

  // A length field of zero encodes a full 1024-sample frame.
  function automatic logic [CNT_W-1:0] len_decode(input logic [ADDR_W-1:0] l);
    return (l == '0) ? CNT_W'(MAX_LEN) : {1'b0, l};
  endfunction
endpackage

// File: rtl/fas_stream_src_if.sv
// Control, pattern-RAM and sample-stream signals of the FAS stream source.
// master = the source block, slave = its environment (controller, RAM, FAS).
interface fas_stream_src_if;
  logic                                 start;
  logic        [fas_pkg::ADDR_W-1:0]    len;
  logic                                 pause;
  logic                                 mem_en;
  logic        [fas_pkg::ADDR_W-1:0]    mem_addr;
  logic signed [fas_pkg::SAMPLE_W-1:0]  mem_rdata;
  logic                                 data_valid;
  logic signed [fas_pkg::SAMPLE_W-1:0]  data;
  logic                                 busy;
  logic                                 done;

  modport master (
    input  start, len, pause, mem_rdata,
    output mem_en, mem_addr, data_valid, data, busy, done
  );

  modport slave (
    output start, len, pause, mem_rdata,
    input  mem_en, mem_addr, data_valid, data, busy, done
  );
endinterface

// File: rtl/fas_src_skid.sv
// One-entry skid register that parks the RAM word still in flight when the
// stream is paused.
module fas_src_skid
  import fas_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       pop,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic                       vld,
  output logic signed [SAMPLE_W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (pop) begin
      vld  <= 1'b0;
      dout <= '0;
    end
  end

endmodule

// File: rtl/fas_stream_src.sv
// Frame sequencer: reads L pattern words from RAM, streams them to FAS with
// pause/skid support, appends FLUSH_LEN zero samples and pulses done.
module fas_stream_src
  import fas_pkg::*;
#(
  parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
  input  logic              clk,
  input  logic              rst,
  fas_stream_src_if.master  bus
);

  localparam int                FCNT_W  = $clog2(FLUSH_LEN + 1);
  localparam logic [FCNT_W-1:0] FLUSH_N = FCNT_W'(FLUSH_LEN);

  fas_state_e                 state, state_nxt;
  logic        [CNT_W-1:0]    len_q;
  logic        [CNT_W-1:0]    addr_p0;
  logic        [CNT_W-1:0]    out_cnt;
  logic        [FCNT_W-1:0]   fcnt;
  logic                       rd_en_p0;
  logic                       rd_vld_p1;
  logic                       vld_p2;
  logic signed [SAMPLE_W-1:0] data_p2;
  logic                       skid_vld;
  logic signed [SAMPLE_W-1:0] skid_data;
  logic                       start_acc;
  logic                       emit;
  logic                       flush_emit;
  logic                       skid_load;
  logic                       skid_pop;
  logic signed [SAMPLE_W-1:0] emit_data;

  always_comb begin
    state_nxt  = state;
    start_acc  = 1'b0;
    rd_en_p0   = 1'b0;
    emit       = 1'b0;
    flush_emit = 1'b0;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    emit_data  = skid_vld ? skid_data : bus.mem_rdata;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (!bus.pause) begin
          rd_en_p0  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (bus.pause) begin
          skid_load = rd_vld_p1;
        end else begin
          // Skid and in-flight read are never both occupied: no read issues while paused.
          rd_en_p0 = (addr_p0 < len_q);
          emit     = skid_vld | rd_vld_p1;
          skid_pop = skid_vld;
          if (emit && (out_cnt == len_q - CNT_W'(1))) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt == FLUSH_N) state_nxt = FIN;
        else                 flush_emit = !bus.pause;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: read issue / p1: RAM word returning / p2: registered sample to FAS
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_p0   <= '0;
      out_cnt   <= '0;
      fcnt      <= '0;
      rd_vld_p1 <= 1'b0;
      vld_p2    <= 1'b0;
      data_p2   <= '0;
    end else begin
      state     <= state_nxt;
      rd_vld_p1 <= rd_en_p0;
      if (start_acc) begin
        len_q   <= len_decode(bus.len);
        addr_p0 <= '0;
        out_cnt <= '0;
        fcnt    <= '0;
      end else begin
        if (rd_en_p0)   addr_p0 <= addr_p0 + CNT_W'(1);
        if (emit)       out_cnt <= out_cnt + CNT_W'(1);
        if (flush_emit) fcnt    <= fcnt + FCNT_W'(1);
      end
      vld_p2  <= emit | flush_emit;
      data_p2 <= emit ? emit_data : '0;
    end
  end

  fas_src_skid u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .load (skid_load),
    .pop  (skid_pop),
    .din  (bus.mem_rdata),
    .vld  (skid_vld),
    .dout (skid_data)
  );

  assign bus.mem_en     = rd_en_p0;
  assign bus.mem_addr   = addr_p0[ADDR_W-1:0];
  assign bus.data_valid = vld_p2;
  assign bus.data       = data_p2;
  assign bus.busy       = (state != IDLE) | start_acc;
  assign bus.done       = (state == FIN);

endmodule

// File: tb/tb_fas_stream_src.sv
// Directed bench for fas_stream_src: synchronous pattern RAM model, per-cycle
// capture of the stream, and hand-derived cycle/sample expectations.
module tb_fas_stream_src;
  import fas_pkg::*;

  localparam int CAPN = 1100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fas_stream_src_if bus ();

  fas_stream_src #(.FLUSH_LEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] ram [1024];
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= ram[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  logic        cap_dv   [CAPN];
  logic [15:0] cap_d    [CAPN];
  logic        cap_done [CAPN];
  logic        cap_busy [CAPN];
  logic        cap_men  [CAPN];
  logic [9:0]  cap_addr [CAPN];

  // Start at cycle 0 (and optionally at s2/s3), pause over [p_at, p_at+p_n).
  task automatic run_frame(input logic [9:0] l, input int ncyc, input int p_at,
                           input int p_n, input int s2_at, input int s3_at);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 0) || (k == s2_at) || (k == s3_at);
      bus.len   = l;
      bus.pause = (k >= p_at) && (k < p_at + p_n);
      @(negedge clk);
      cap_dv[k]   = bus.data_valid;
      cap_d[k]    = bus.data;
      cap_done[k] = bus.done;
      cap_busy[k] = bus.busy;
      cap_men[k]  = bus.mem_en;
      cap_addr[k] = bus.mem_addr;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.start = 1'b0; bus.len = '0; bus.pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.mem_en, bus.mem_addr, bus.busy, bus.done} !== 13'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {bus.mem_en, bus.mem_addr, bus.busy, bus.done});
    end
    total++;
    if ({bus.data_valid, bus.data} !== 17'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {bus.data_valid, bus.data});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.pause = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_en, bus.busy, bus.data_valid} !== 3'b000) begin
      bad++; $display("FAIL idle_pause got=%b want=000", {bus.mem_en, bus.busy, bus.data_valid});
    end
    @(posedge clk); #1;
    bus.pause = 1'b0;
  endtask

  task automatic test_full_frame();
    int first = -1, last = -1, nv = 0, seq_err = 0, first_bad = -1, zero_err = 0, ndone = 0, done_at = -1;
    logic [15:0] exp_d;
    for (int a = 0; a < 1024; a++) ram[a] = 16'(a);
    run_frame(10'd0, 1050, -1, 0, -1, -1);
    for (int k = 0; k < 1050; k++) begin
      if (cap_dv[k]) begin
        if (first < 0) first = k;
        last  = k;
        exp_d = (nv < 1024) ? 16'(nv) : 16'h0000;
        if (cap_d[k] !== exp_d) begin
          seq_err++;
          if (first_bad < 0) first_bad = nv;
        end
        nv++;
      end else if (cap_d[k] !== 16'h0000) zero_err++;
      if (cap_done[k]) begin ndone++; done_at = k; end
    end
    total++; if (first !== 3)    begin bad++; $display("FAIL full_first_dv got=%0d want=3", first); end
    total++; if (nv !== 1040)    begin bad++; $display("FAIL full_dv_count got=%0d want=1040", nv); end
    total++; if (last !== 1042)  begin bad++; $display("FAIL full_last_dv got=%0d want=1042", last); end
    total++; if (seq_err !== 0)  begin bad++; $display("FAIL full_samples got=%0d errors (first at sample %0d) want=0", seq_err, first_bad); end
    total++; if (zero_err !== 0) begin bad++; $display("FAIL full_idle_zero got=%0d want=0", zero_err); end
    total++; if (ndone !== 1)    begin bad++; $display("FAIL full_done_count got=%0d want=1", ndone); end
    total++; if (done_at !== 1043) begin bad++; $display("FAIL full_done_cycle got=%0d want=1043", done_at); end
  endtask

  task automatic test_short_frame();
    logic [15:0] q[$];
    logic [15:0] exp_q[$];
    int nbusy = 0, done_at = -1, seq_err = 0;
    ram[0] = 16'hAAAA; ram[1] = 16'hBBBB; ram[2] = 16'hCCCC; ram[3] = 16'hDDDD;
    exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0000);
    run_frame(10'd4, 30, -1, 0, -1, -1);
    for (int k = 0; k < 30; k++) begin
      if (cap_dv[k]) q.push_back(cap_d[k]);
      if (cap_busy[k]) nbusy++;
      if (cap_done[k]) done_at = k;
    end
    total++; if (q.size() !== 20) begin bad++; $display("FAIL short_count got=%0d want=20", q.size()); end
    for (int i = 0; i < 20 && i < q.size(); i++) if (q[i] !== exp_q[i]) seq_err++;
    total++; if (seq_err !== 0) begin bad++; $display("FAIL short_samples got=%0d errors want=0", seq_err); end
    total++; if (cap_dv[3] !== 1'b1 || cap_d[3] !== 16'hAAAA) begin
      bad++; $display("FAIL short_first got=%b/%h want=1/aaaa", cap_dv[3], cap_d[3]);
    end
    total++; if (nbusy !== 24) begin bad++; $display("FAIL short_busy_cycles got=%0d want=24", nbusy); end
    total++; if (done_at !== 23) begin bad++; $display("FAIL short_done_cycle got=%0d want=23", done_at); end
    total++; if (cap_busy[24] !== 1'b0) begin bad++; $display("FAIL short_busy_after got=%b want=0", cap_busy[24]); end
  endtask

  task automatic test_pause();
    logic [15:0] q[$];
    int first = -1, last = -1, gap = 0, zero_err = 0, men_p = 0, done_at = -1, seq_err = 0;
    for (int i = 0; i < 8; i++) ram[i] = 16'h1000 + 16'(i);
    run_frame(10'd8, 40, 5, 5, -1, -1);
    for (int k = 0; k < 40; k++) begin
      if (cap_dv[k]) begin
        if (first < 0) first = k;
        last = k;
        q.push_back(cap_d[k]);
      end else if (cap_d[k] !== 16'h0000) zero_err++;
      if (cap_done[k]) done_at = k;
      if (k >= 5 && k < 10 && cap_men[k]) men_p++;
    end
    for (int k = first; k <= last; k++) if (!cap_dv[k]) gap++;
    total++; if (q.size() !== 24) begin bad++; $display("FAIL pause_count got=%0d want=24", q.size()); end
    for (int i = 0; i < 24 && i < q.size(); i++)
      if (q[i] !== ((i < 8) ? 16'h1000 + 16'(i) : 16'h0000)) seq_err++;
    total++; if (seq_err !== 0)  begin bad++; $display("FAIL pause_samples got=%0d errors want=0", seq_err); end
    total++; if (gap !== 5)      begin bad++; $display("FAIL pause_gap got=%0d want=5", gap); end
    total++; if (cap_dv[6] !== 1'b0 || cap_dv[11] !== 1'b1 || cap_d[11] !== 16'h1003) begin
      bad++; $display("FAIL pause_resume got=%b/%b/%h want=0/1/1003", cap_dv[6], cap_dv[11], cap_d[11]);
    end
    total++; if (zero_err !== 0) begin bad++; $display("FAIL pause_gap_zero got=%0d want=0", zero_err); end
    total++; if (men_p !== 0)    begin bad++; $display("FAIL pause_mem_en got=%0d want=0", men_p); end
    total++; if (done_at !== 32) begin bad++; $display("FAIL pause_done_cycle got=%0d want=32", done_at); end
  endtask

  task automatic test_restart();
    int ndone = 0, nv = 0, nbusy = 0;
    ram[0] = 16'hAAAA; ram[1] = 16'hBBBB; ram[2] = 16'hCCCC; ram[3] = 16'hDDDD;
    run_frame(10'd4, 45, -1, 0, 10, 23);
    for (int k = 0; k < 45; k++) begin
      if (cap_done[k]) ndone++;
      if (cap_dv[k])   nv++;
      if (cap_busy[k]) nbusy++;
    end
    total++; if (ndone !== 1)  begin bad++; $display("FAIL restart_done_count got=%0d want=1", ndone); end
    total++; if (nv !== 20)    begin bad++; $display("FAIL restart_dv_count got=%0d want=20", nv); end
    total++; if (nbusy !== 24) begin bad++; $display("FAIL restart_busy_cycles got=%0d want=24", nbusy); end
  endtask

  task automatic test_reset_mid();
    int dv_after = 0, first_men = -1;
    for (int a = 0; a < 1024; a++) ram[a] = 16'(a);
    for (int k = 0; k <= 102; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 0);
      bus.len   = 10'd0;
      bus.pause = 1'b0;
      if (k == 102) rst = 1'b0;
      @(negedge clk);
    end
    total++;
    if ({bus.data_valid, bus.data} !== {1'b1, 16'd99}) begin
      bad++; $display("FAIL rmid_100th got=%b/%h want=1/0063", bus.data_valid, bus.data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_en, bus.mem_addr, bus.data_valid, bus.data, bus.busy, bus.done} !== 30'd0) begin
      bad++; $display("FAIL rmid_outputs got=%h want=0",
                      {bus.mem_en, bus.mem_addr, bus.data_valid, bus.data, bus.busy, bus.done});
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.data_valid || bus.busy) dv_after++;
    end
    total++; if (dv_after !== 0) begin bad++; $display("FAIL rmid_quiet got=%0d want=0", dv_after); end
    run_frame(10'd3, 30, -1, 0, -1, -1);
    for (int k = 0; k < 30; k++) if (cap_men[k] && first_men < 0) first_men = k;
    total++; if (first_men !== 1) begin bad++; $display("FAIL rmid_first_read got=%0d want=1", first_men); end
    total++; if (cap_addr[1] !== 10'd0) begin bad++; $display("FAIL rmid_first_addr got=%0d want=0", cap_addr[1]); end
    total++;
    if ({cap_dv[3], cap_d[3], cap_dv[4], cap_d[4], cap_dv[5], cap_d[5]} !== {1'b1, 16'd0, 1'b1, 16'd1, 1'b1, 16'd2}) begin
      bad++; $display("FAIL rmid_restream got=%h/%h/%h want=0000/0001/0002", cap_d[3], cap_d[4], cap_d[5]);
    end
  endtask

  task automatic test_start_pause();
    int first_men = -1, first_dv = -1, done_at = -1;
    ram[0] = 16'h1234; ram[1] = 16'h8001;
    run_frame(10'd2, 30, 0, 3, -1, -1);
    for (int k = 0; k < 30; k++) begin
      if (cap_men[k] && first_men < 0) first_men = k;
      if (cap_dv[k] && first_dv < 0)   first_dv = k;
      if (cap_done[k]) done_at = k;
    end
    total++; if (first_men !== 3) begin bad++; $display("FAIL sp_first_read got=%0d want=3", first_men); end
    total++; if (first_dv !== 5)  begin bad++; $display("FAIL sp_first_dv got=%0d want=5", first_dv); end
    total++; if ({cap_d[5], cap_d[6]} !== {16'h1234, 16'h8001}) begin
      bad++; $display("FAIL sp_samples got=%h/%h want=1234/8001", cap_d[5], cap_d[6]);
    end
    total++; if (done_at !== 23) begin bad++; $display("FAIL sp_done_cycle got=%0d want=23", done_at); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_pause();
    test_restart();
    test_reset_mid();
    test_start_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
